// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_pkg
//  Description : Shared types and constants for the MAC PE job sequencer:
//                FSM state encoding, widths and the lane-select decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

    localparam int NUM_ACC   = 8;
    localparam int ACC_SEL_W = $clog2(NUM_ACC);
    localparam int K_W       = 8;
    localparam int NUM_SRC   = 3;
    localparam int SRC_W     = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Lane 3 does not exist on the PE; it aliases to lane 0.
    function automatic logic [NUM_SRC-1:0] src_onehot(input logic [SRC_W-1:0] src);
        logic [NUM_SRC-1:0] oh;
        case (src)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b001;
        endcase
        return oh;
    endfunction

endpackage : mac_pkg
`default_nettype wire

// File: rtl/mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mac_seq_ctrl
//  Description : Job sequencer for one MAC PE. Accepts a {K, N, lane} job,
//                drives PE clear / valid_ctrl / weight_valid / acc_sel in
//                step with an operand valid/ready stream, and tags each PE
//                result with its accumulator index and a final-sum flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_seq_ctrl
    import mac_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [K_W-1:0]       cfg_k,
    input  logic [ACC_SEL_W-1:0] cfg_nacc,
    input  logic [SRC_W-1:0]     cfg_src,
    input  logic                 abort,
    input  logic                 op_valid,
    output logic                 op_ready,
    output logic                 mac_clear,
    output logic [NUM_SRC-1:0]   mac_valid_ctrl,
    output logic                 mac_weight_valid,
    output logic [ACC_SEL_W-1:0] mac_acc_sel,
    output logic                 res_last,
    output logic [ACC_SEL_W-1:0] res_acc,
    output logic                 busy,
    output logic                 done
);

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [K_W-1:0]         r_cfg_k;
    logic [ACC_SEL_W-1:0]   r_nacc;
    logic [SRC_W-1:0]       r_src;
    logic [K_W-1:0]         r_k_cnt;
    logic [ACC_SEL_W-1:0]   r_a_cnt;
    logic                   r_abort_clr;
    logic                   r_res_last;
    logic [ACC_SEL_W-1:0]   r_res_acc;

    logic                   w_abort;
    logic                   w_accept;
    logic                   w_op_ready;
    logic                   w_fire;
    logic                   w_a_wrap;
    logic                   w_k_last;
    logic                   w_last_fire;
    logic                   w_cfg_ready;
    logic                   w_busy;
    logic                   w_done;
    logic                   w_clear_st;

    // ------------------------------------------------------------------
    // Combinational handshake / fire path. Abort kills ready in the same
    // cycle so no operand is consumed by a job being cancelled.
    // ------------------------------------------------------------------
    assign w_abort     = abort & (r_state != ST_IDLE);
    assign w_accept    = cfg_valid & (r_state == ST_IDLE);
    assign w_op_ready  = (r_state == ST_RUN) & ~abort;
    assign w_fire      = op_valid & w_op_ready;
    assign w_a_wrap    = (r_a_cnt == r_nacc);
    assign w_k_last    = (r_k_cnt == (r_cfg_k - K_W'(1)));
    assign w_last_fire = w_fire & w_a_wrap & w_k_last;

    assign op_ready         = w_op_ready;
    assign mac_weight_valid = w_fire;
    assign mac_valid_ctrl   = w_fire ? src_onehot(r_src) : '0;
    assign mac_acc_sel      = r_a_cnt;
    assign res_last         = r_res_last;
    assign res_acc          = r_res_acc;
    assign cfg_ready        = w_cfg_ready;
    assign busy             = w_busy;
    assign done             = w_done;
    // The abort-clear pulse lands in the IDLE cycle following the abort.
    assign mac_clear        = w_clear_st | r_abort_clr;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and state-derived outputs; abort overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        w_cfg_ready = 1'b0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        w_clear_st  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cfg_ready = 1'b1;
                w_busy      = 1'b0;
                if (cfg_valid) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_clear_st  = 1'b1;
                w_state_nxt = (r_cfg_k != '0) ? ST_RUN : ST_DRAIN;
            end
            ST_RUN: begin
                if (w_last_fire) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Job descriptor latch, step counters and result tags registered on each fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_k     <= '0;
            r_nacc      <= '0;
            r_src       <= '0;
            r_k_cnt     <= '0;
            r_a_cnt     <= '0;
            r_abort_clr <= 1'b0;
            r_res_last  <= 1'b0;
            r_res_acc   <= '0;
        end else begin
            r_abort_clr <= w_abort;
            if (w_accept) begin
                r_cfg_k <= cfg_k;
                r_nacc  <= cfg_nacc;
                r_src   <= cfg_src;
                r_k_cnt <= '0;
                r_a_cnt <= '0;
            end else if (w_abort) begin
                r_k_cnt <= '0;
                r_a_cnt <= '0;
            end else if (w_fire) begin
                // Accumulator index rotates fastest; step count advances on wrap.
                if (w_a_wrap) begin
                    r_a_cnt <= '0;
                    r_k_cnt <= r_k_cnt + K_W'(1);
                end else begin
                    r_a_cnt <= r_a_cnt + ACC_SEL_W'(1);
                end
                r_res_acc  <= r_a_cnt;
                r_res_last <= w_k_last;
            end
        end
    end

endmodule : mac_seq_ctrl
`default_nettype wire

// File: tb/tb_mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_seq_ctrl
//  Description : Directed bench for mac_seq_ctrl driving a small behavioural
//                MAC PE (W=8, ACC_W=16). Expected PE results are queued when
//                a job is issued and retired as the PE reports valid_out.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_seq_ctrl;
    import mac_pkg::*;

    localparam int ACC_W = 16;
    localparam int WGT   = 2;

    logic                 clk;
    logic                 rst;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [K_W-1:0]       cfg_k;
    logic [ACC_SEL_W-1:0] cfg_nacc;
    logic [SRC_W-1:0]     cfg_src;
    logic                 abort;
    logic                 op_valid;
    logic                 op_ready;
    logic                 mac_clear;
    logic [NUM_SRC-1:0]   mac_valid_ctrl;
    logic                 mac_weight_valid;
    logic [ACC_SEL_W-1:0] mac_acc_sel;
    logic                 res_last;
    logic [ACC_SEL_W-1:0] res_acc;
    logic                 busy;
    logic                 done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [ACC_SEL_W-1:0] acc;
        logic                 last;
        logic [ACC_W-1:0]     sum;
    } exp_t;
    exp_t sb_q[$];

    mac_seq_ctrl u_dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_k            (cfg_k),
        .cfg_nacc         (cfg_nacc),
        .cfg_src          (cfg_src),
        .abort            (abort),
        .op_valid         (op_valid),
        .op_ready         (op_ready),
        .mac_clear        (mac_clear),
        .mac_valid_ctrl   (mac_valid_ctrl),
        .mac_weight_valid (mac_weight_valid),
        .mac_acc_sel      (mac_acc_sel),
        .res_last         (res_last),
        .res_acc          (res_acc),
        .busy             (busy),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural PE: lanes carry fixed activations 5/3/7, weight is 2.
    logic [ACC_W-1:0] pe_acc [NUM_ACC];
    logic             pe_valid_out;
    logic [ACC_W-1:0] pe_acc_out;
    logic [7:0]       pe_a;
    assign pe_a = (mac_valid_ctrl[0] ? 8'd5 : 8'd0) +
                  (mac_valid_ctrl[1] ? 8'd3 : 8'd0) +
                  (mac_valid_ctrl[2] ? 8'd7 : 8'd0);

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ACC; i++) pe_acc[i] <= '0;
            pe_valid_out <= 1'b0;
            pe_acc_out   <= '0;
        end else begin
            pe_valid_out <= 1'b0;
            if (mac_clear) begin
                for (int i = 0; i < NUM_ACC; i++) pe_acc[i] <= '0;
            end else if (mac_weight_valid && (|mac_valid_ctrl)) begin
                pe_acc[mac_acc_sel] <= pe_acc[mac_acc_sel] + ACC_W'(pe_a) * ACC_W'(WGT);
                pe_acc_out          <= pe_acc[mac_acc_sel] + ACC_W'(pe_a) * ACC_W'(WGT);
                pe_valid_out        <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int lane_act(input int src);
        case (src)
            1:       return 3;
            2:       return 7;
            default: return 5;
        endcase
    endfunction

    function automatic logic [NUM_SRC-1:0] lane_oh(input int src);
        case (src)
            1:       return 3'b010;
            2:       return 3'b100;
            default: return 3'b001;
        endcase
    endfunction

    // Scoreboard retire: every PE result must match the oldest queued expectation.
    always @(negedge clk) begin
        if (pe_valid_out) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("res_acc", 32'(res_acc), 32'(e.acc));
                check("res_last", 32'(res_last), 32'(e.last));
                check("acc_out", 32'(pe_acc_out), 32'(e.sum));
            end
        end
    end

    // Issue one job and follow it cycle by cycle. stop_after >= 0 aborts
    // (or resets, when use_rst) once that many fires have occurred.
    task automatic run_job(input string tag, input int k, input int nacc, input int src,
                           input bit toggle, input int stop_after, input bit use_rst,
                           input bit hold, input int exp_lat);
        int cyc;
        int fires;
        int clears;
        int rdy_seen;
        int ea;
        bit done_seen;
        exp_t e;
        @(negedge clk);
        cfg_k     = K_W'(k);
        cfg_nacc  = ACC_SEL_W'(nacc);
        cfg_src   = SRC_W'(src);
        cfg_valid = 1'b1;
        abort     = 1'b0;
        op_valid  = toggle ? 1'b0 : 1'b1;
        #1;
        check({tag, "_cfg_ready_idle"}, 32'(cfg_ready), 32'd1);
        for (int kk = 0; kk < k; kk++) begin
            for (int aa = 0; aa <= nacc; aa++) begin
                e.acc  = ACC_SEL_W'(aa);
                e.last = (kk == k - 1);
                e.sum  = ACC_W'((kk + 1) * lane_act(src) * WGT);
                sb_q.push_back(e);
            end
        end
        cyc = 0; fires = 0; clears = 0; rdy_seen = 0; ea = 0; done_seen = 1'b0;
        while (!done_seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (!hold) cfg_valid = 1'b0;
            op_valid = toggle ? 1'(cyc % 2) : 1'b1;
            if (stop_after >= 0 && fires == stop_after) begin
                if (use_rst) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    #1;
                    check({tag, "_rst_busy"}, 32'(busy), 32'd0);
                    check({tag, "_rst_cfg_ready"}, 32'(cfg_ready), 32'd1);
                    check({tag, "_rst_clear"}, 32'(mac_clear), 32'd0);
                    check({tag, "_rst_acc_sel"}, 32'(mac_acc_sel), 32'd0);
                    check({tag, "_rst_res_last"}, 32'(res_last), 32'd0);
                    check({tag, "_rst_res_acc"}, 32'(res_acc), 32'd0);
                    check({tag, "_rst_done"}, 32'(done), 32'd0);
                    check({tag, "_rst_op_ready"}, 32'(op_ready), 32'd0);
                end else begin
                    abort = 1'b1;
                    #1;
                    check({tag, "_abort_op_ready"}, 32'(op_ready), 32'd0);
                    check({tag, "_abort_no_fire"}, 32'(mac_weight_valid), 32'd0);
                    @(negedge clk);
                    abort = 1'b0;
                    #1;
                    check({tag, "_abort_idle"}, 32'(busy), 32'd0);
                    check({tag, "_abort_cfg_ready"}, 32'(cfg_ready), 32'd1);
                    check({tag, "_abort_clear"}, 32'(mac_clear), 32'd1);
                    check({tag, "_abort_no_done"}, 32'(done), 32'd0);
                    @(negedge clk);
                    #1;
                    check({tag, "_abort_clear_end"}, 32'(mac_clear), 32'd0);
                    check({tag, "_abort_no_done2"}, 32'(done), 32'd0);
                    check({tag, "_abort_acc0_zero"}, 32'(pe_acc[0]), 32'd0);
                    check({tag, "_abort_acc1_zero"}, 32'(pe_acc[1]), 32'd0);
                end
                sb_q.delete();
                op_valid = 1'b0;
                return;
            end
            #1;
            if (op_ready) rdy_seen++;
            if (mac_clear) clears++;
            if (!done) begin
                check({tag, "_busy"}, 32'(busy), 32'd1);
                check({tag, "_cfg_ready_busy"}, 32'(cfg_ready), 32'd0);
            end
            if (mac_weight_valid) begin
                check({tag, "_valid_ctrl"}, 32'(mac_valid_ctrl), 32'(lane_oh(src)));
                check({tag, "_acc_sel"}, 32'(mac_acc_sel), 32'(ea));
                fires++;
                ea = (ea == nacc) ? 0 : ea + 1;
            end
            if (done) done_seen = 1'b1;
        end
        op_valid = 1'b0;
        check({tag, "_done_seen"}, 32'(done_seen), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_fires"}, 32'(fires), 32'(k * (nacc + 1)));
        check({tag, "_clear_pulses"}, 32'(clears), 32'd1);
        if (k == 0) check({tag, "_op_ready_never"}, 32'(rdy_seen), 32'd0);
        check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_k     = '0;
        cfg_nacc  = '0;
        cfg_src   = '0;
        abort     = 1'b0;
        op_valid  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_cfg_ready", 32'(cfg_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_clear", 32'(mac_clear), 32'd0);
        check("reset_acc_sel", 32'(mac_acc_sel), 32'd0);
        check("reset_res_last", 32'(res_last), 32'd0);
        check("reset_res_acc", 32'(res_acc), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Abort while idle must be ignored.
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("idle_abort_clear", 32'(mac_clear), 32'd0);

        // Basic job: 4 fires on lane 1, both accumulators reach 12.
        run_job("t1", 2, 1, 1, 1'b0, -1, 1'b0, 1'b0, 7);
        check("t1_acc0", 32'(pe_acc[0]), 32'd12);
        check("t1_acc1", 32'(pe_acc[1]), 32'd12);

        // Same job with operand stalls every other cycle.
        run_job("t2", 2, 1, 1, 1'b1, -1, 1'b0, 1'b0, 11);
        check("t2_acc0", 32'(pe_acc[0]), 32'd12);
        check("t2_acc1", 32'(pe_acc[1]), 32'd12);

        // Empty job.
        run_job("t3", 0, 2, 2, 1'b0, -1, 1'b0, 1'b0, 3);

        // All eight accumulators, lane 3 aliased to lane 0.
        run_job("t4", 1, 7, 3, 1'b0, -1, 1'b0, 1'b0, 11);
        for (int i = 0; i < NUM_ACC; i++) check("t4_acc", 32'(pe_acc[i]), 32'd10);

        // Abort after two fires, then a normal job.
        run_job("t5", 4, 1, 0, 1'b0, 2, 1'b0, 1'b0, 0);
        run_job("t5b", 2, 1, 1, 1'b0, -1, 1'b0, 1'b0, 7);
        check("t5b_acc0", 32'(pe_acc[0]), 32'd12);

        // Reset mid-run, then a descriptor held through a busy job.
        run_job("t6", 3, 2, 2, 1'b0, 3, 1'b1, 1'b0, 0);
        run_job("t6a", 1, 0, 2, 1'b0, -1, 1'b0, 1'b1, 4);
        run_job("t6b", 1, 0, 2, 1'b0, -1, 1'b0, 1'b0, 4);
        check("t6b_acc0", 32'(pe_acc[0]), 32'd14);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mac_seq_ctrl
`default_nettype wire
